fpu_arbiter: RTL and testbench
==============================

# fpu_arbiter

Sequencer and two-port round-robin arbiter for the shared square / square-accumulate FPU coprocessor. Two requesters, such as two darkriscv cores or a core and a DMA-driven kernel engine, submit operations through valid/ready handshakes. The block latches the operands and drives the FPU's chip-select protocol, including the flush and drain steps that the reset-less FPU needs. It returns each 32-bit result to its owning port.

## Interface
- `DRAIN`, default 64: post-reset cycles with `fpu_cs`=0 before any request is accepted. Must be ≥ the FPU's worst-case operation latency.
- `clk` in 1: system clock, rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `req_valid0`, `req_valid1` in 1: operation request.
- `req_ready0`, `req_ready1` out 1: accept; a transfer occurs on valid&ready.
- `req_func0`, `req_func1` in 3: operation select; 1 = square, 2 = square-accumulate; passed through unchanged.
- `req_rs1_0`, `req_rs1_1`, `req_rs2_0`, `req_rs2_1`, `req_rdr0`, `req_rdr1` in 32: IEEE-754 single-precision operands.
- `rsp_valid0`, `rsp_valid1` out 1: result available.
- `rsp_ready0`, `rsp_ready1` in 1: result consumed.
- `rsp_data0`, `rsp_data1` out 32: result word.
- `fpu_cs` out 1: FPU chip-select.
- `fpu_func` out 3: FPU operation select.
- `fpu_rs1`, `fpu_rs2`, `fpu_rdr` out 32: FPU operands.
- `fpu_ready` in 1: FPU done.
- `fpu_rdw` in 32: FPU result; valid only while `fpu_cs`=1.
- `busy` out 1: high in every state except IDLE.

## Operation
FPU contract this block relies on:
- The FPU samples operands and `func` on the first `cs`=1 cycle while it is idle.
- It reads `func` again mid-operation, so `func` must stay stable for the whole operation.
- It asserts `ready` while done.
- A done FPU that sees `cs`=1 at a clock edge returns to idle.
- If `cs` is still 1 while idle, a new operation starts.
- The FPU has no reset.

States:
- **DRAIN**
  - Entered on reset; the counter loads `DRAIN`−1.
  - `fpu_cs`=0 and all `req_ready`=0.
  - Counter decrements each cycle; at 0 → IDLE.
  - Purpose: an operation interrupted by reset runs to completion inside the FPU.
- **IDLE**
  - Grant rule:
    - Exactly one `req_valid` high: that port is granted.
    - Both high: the port other than `last` is granted.
    - `req_ready` of the granted port is high combinationally in IDLE; all other `req_ready` outputs are 0.
  - On handshake:
    - Latch func, rs1, rs2 and rdr into the `fpu_*` registers.
    - Set `owner` to the granted port and `last` to `owner`.
    - `fpu_cs` is registered to 1.
    - Next state is FLUSH if `fpu_ready`=1 (stale done left over from a reset mid-operation), otherwise BUSY.
- **FLUSH**
  - `fpu_cs`=1 for exactly one cycle; the FPU leaves done and enters idle.
  - → BUSY with `fpu_cs` held at 1, so the FPU starts on the next edge with the latched operands.
- **BUSY**
  - `fpu_cs`=1.
  - When `fpu_ready`=1: capture `fpu_rdw` into `rsp_data[owner]`, register `fpu_cs`←0, → RESP.
- **RESP**
  - `rsp_valid[owner]`=1; `rsp_data[owner]` stays stable until the handshake completes.
  - On `rsp_ready[owner]`=1: `rsp_valid`←0, → IDLE.
  - The non-owning port is never granted in RESP.

Rules:
- The `fpu_*` operand and func outputs change only in IDLE on a handshake.
- `rsp_data` of each port holds its last result until that port's next capture.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values:
  - State DRAIN; `last`=1, so port 0 wins the first tie.
  - All `req_ready`=0, all `rsp_valid`=0, all `rsp_data`=0.
  - `fpu_cs`=0, `fpu_func`=0, all FPU operands 0.
  - `busy`=1.
- First accept is possible at cycle `DRAIN` after reset deassertion.
- Handshake at cycle T: `fpu_cs`=1 from T+1 (T+2 for the FPU start if FLUSH is taken).
- The FPU raises `fpu_ready` at cycle T+1+L, where L is the FPU latency. The result is captured at that edge, `fpu_cs`=0 from T+2+L, and `rsp_valid`=1 from T+2+L.
- `fpu_cs` drops in the same cycle the FPU returns to idle, so a request is never issued twice.
- `rsp_ready` already high when `rsp_valid` rises: RESP lasts 1 cycle; the next accept is possible the following cycle.
- Reset asserted mid-operation: all outputs return to reset values immediately; DRAIN is re-entered; the pending result is discarded.
- Requests that arrive during DRAIN, BUSY or RESP are held off (`req_ready`=0); valid must stay asserted.

## Test plan
- **Single square.** `DRAIN`=64. Port 0: func=1, rs1=0x40000000. Required: `req_ready0` at cycle 64 and `rsp_data0`=0x40800000 with `rsp_valid0` 1 cycle after `fpu_ready`. `fpu_cs` is high exactly from accept+1 through the `fpu_ready` cycle.
- **Square-accumulate.** Port 1: func=2, rs1=0x40400000, rs2=0x3F800000, rdr=0x3F800000. Required: `rsp_data1`=0x40A00000.
- **Tie arbitration.** Both ports request continuously, 4 operations each. Required: grants alternate 0, 1, 0, 1, …, starting with port 0 after reset, and each port receives only its own results.
- **Response backpressure.** Hold `rsp_ready0`=0 for 10 cycles. Required: `rsp_valid0` and `rsp_data0` stay stable; `req_ready1` stays 0 throughout; port 1 is granted the cycle after the response handshake.
- **Reset mid-operation.** Assert `rstn`=0 for 1 cycle 5 cycles into BUSY, then request 0x40000000 squared. Required: no accept during the 64 DRAIN cycles; the FLUSH state is traversed (one extra `fpu_cs` cycle); the result is 0x40800000, not stale data.
- **Request during DRAIN.** Hold `req_valid0`=1 from reset release. Required: `req_ready0` is first high at cycle `DRAIN`; exactly one operation is issued.

Source files
------------

// File: rtl/fpu_arbiter.sv
// Two-port round-robin front end for the shared square / square-accumulate FPU.
// Drives the reset-less FPU's chip-select protocol, including the post-reset drain and stale-done flush.
module fpu_arbiter #(
  parameter int unsigned DRAIN = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid0,
  input  logic        req_valid1,
  output logic        req_ready0,
  output logic        req_ready1,
  input  logic [2:0]  req_func0,
  input  logic [2:0]  req_func1,
  input  logic [31:0] req_rs1_0,
  input  logic [31:0] req_rs1_1,
  input  logic [31:0] req_rs2_0,
  input  logic [31:0] req_rs2_1,
  input  logic [31:0] req_rdr0,
  input  logic [31:0] req_rdr1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  input  logic        rsp_ready0,
  input  logic        rsp_ready1,
  output logic [31:0] rsp_data0,
  output logic [31:0] rsp_data1,
  output logic        fpu_cs,
  output logic [2:0]  fpu_func,
  output logic [31:0] fpu_rs1,
  output logic [31:0] fpu_rs2,
  output logic [31:0] fpu_rdr,
  input  logic        fpu_ready,
  input  logic [31:0] fpu_rdw,
  output logic        busy
);

  localparam int unsigned CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_FLUSH,
    S_BUSY,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        fpu_cs_q, fpu_cs_d;
  logic [2:0]  func_q, func_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] rdr_q, rdr_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data0_q, rsp_data0_d;
  logic [31:0] rsp_data1_q, rsp_data1_d;

  logic        any_req;
  logic        grant;
  logic        hs;
  logic        rsp_taken;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    any_req = req_valid0 | req_valid1;
    if (req_valid0 && req_valid1) begin
      grant = ~last_q;
    end else begin
      grant = req_valid1;
    end
    hs        = (state_q == S_IDLE) && any_req;
    rsp_taken = owner_q ? rsp_ready1 : rsp_ready0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    fpu_cs_d    = fpu_cs_q;
    func_d      = func_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rdr_d       = rdr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data0_d = rsp_data0_q;
    rsp_data1_d = rsp_data1_q;
    case (state_q)
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_IDLE: begin
        if (hs) begin
          owner_d  = grant;
          last_d   = grant;
          fpu_cs_d = 1'b1;
          func_d   = grant ? req_func1 : req_func0;
          rs1_d    = grant ? req_rs1_1 : req_rs1_0;
          rs2_d    = grant ? req_rs2_1 : req_rs2_0;
          rdr_d    = grant ? req_rdr1  : req_rdr0;
          // A done flag surviving a reset must be cleared before the real start.
          state_d  = fpu_ready ? S_FLUSH : S_BUSY;
        end
      end
      S_FLUSH: begin
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (fpu_ready) begin
          if (owner_q) begin
            rsp_data1_d = fpu_rdw;
          end else begin
            rsp_data0_d = fpu_rdw;
          end
          rsp_valid_d[owner_q] = 1'b1;
          fpu_cs_d             = 1'b0;
          state_d              = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_taken) begin
          rsp_valid_d = '0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_DRAIN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_DRAIN;
      cnt_q       <= CW'(DRAIN - 1);
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      fpu_cs_q    <= 1'b0;
      func_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rdr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      fpu_cs_q    <= fpu_cs_d;
      func_q      <= func_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rdr_q       <= rdr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data0_q <= rsp_data0_d;
      rsp_data1_q <= rsp_data1_d;
    end
  end

  assign req_ready0 = hs && !grant;
  assign req_ready1 = hs && grant;
  assign rsp_valid0 = rsp_valid_q[0];
  assign rsp_valid1 = rsp_valid_q[1];
  assign rsp_data0  = rsp_data0_q;
  assign rsp_data1  = rsp_data1_q;
  assign fpu_cs     = fpu_cs_q;
  assign fpu_func   = func_q;
  assign fpu_rs1    = rs1_q;
  assign fpu_rs2    = rs2_q;
  assign fpu_rdr    = rdr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: behavioural reset-less FPU, per-port request drivers and result scoreboards.
module tb_fpu_arbiter;

  localparam int DRAIN = 64;
  localparam int LAT   = 8;

  logic        clk;
  logic        rstn;
  logic        req_valid0, req_valid1;
  logic        req_ready0, req_ready1;
  logic [2:0]  req_func0, req_func1;
  logic [31:0] req_rs1_0, req_rs1_1, req_rs2_0, req_rs2_1, req_rdr0, req_rdr1;
  logic        rsp_valid0, rsp_valid1;
  logic        rsp_ready0, rsp_ready1;
  logic [31:0] rsp_data0, rsp_data1;
  logic        fpu_cs;
  logic [2:0]  fpu_func;
  logic [31:0] fpu_rs1, fpu_rs2, fpu_rdr;
  logic        fpu_ready;
  logic [31:0] fpu_rdw;
  logic        busy;

  fpu_arbiter #(.DRAIN(DRAIN)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_func0(req_func0), .req_func1(req_func1),
    .req_rs1_0(req_rs1_0), .req_rs1_1(req_rs1_1),
    .req_rs2_0(req_rs2_0), .req_rs2_1(req_rs2_1),
    .req_rdr0(req_rdr0), .req_rdr1(req_rdr1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .fpu_cs(fpu_cs), .fpu_func(fpu_func),
    .fpu_rs1(fpu_rs1), .fpu_rs2(fpu_rs2), .fpu_rdr(fpu_rdr),
    .fpu_ready(fpu_ready), .fpu_rdw(fpu_rdw),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Known single-precision results for the directed cases, an operand hash otherwise.
  function automatic logic [31:0] fpu_fn(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c);
    if (f == 3'd1 && a == 32'h40000000) return 32'h40800000;
    if (f == 3'd1 && a == 32'h3FC00000) return 32'h40100000;
    if (f == 3'd1 && a == 32'h40400000) return 32'h41100000;
    if (f == 3'd2 && a == 32'h40400000 && b == 32'h3F800000 && c == 32'h3F800000) return 32'h40A00000;
    return a ^ {b[15:0], b[31:16]} ^ ~c ^ {29'd0, f};
  endfunction

  // Reset-less FPU: 0 idle, 1 busy, 2 done.
  int          fs = 0;
  int          f_cnt = 0;
  logic [2:0]  f_func = '0;
  logic [31:0] f_res = '0;
  int          starts = 0;
  int          func_err = 0;

  always @(posedge clk) begin
    case (fs)
      0: if (fpu_cs) begin
        fs     <= 1;
        f_cnt  <= LAT - 1;
        f_func <= fpu_func;
        f_res  <= fpu_fn(fpu_func, fpu_rs1, fpu_rs2, fpu_rdr);
        starts <= starts + 1;
      end
      1: begin
        if (fpu_cs && fpu_func != f_func) func_err <= func_err + 1;
        if (f_cnt == 0) fs <= 2;
        else f_cnt <= f_cnt - 1;
      end
      default: if (fpu_cs) fs <= 0;
    endcase
  end

  assign fpu_ready = (fs == 2);
  assign fpu_rdw   = (fs == 2) ? f_res : 32'hBAD0BAD0;

  int cyc;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else cyc <= cyc + 1;
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } req_t;

  req_t        q0[$];
  req_t        q1[$];
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  int          grants[$];

  int acc_cnt0 = 0, acc_cnt1 = 0, rsp_cnt0 = 0, rsp_cnt1 = 0;
  int acc_cyc0 = 0, acc_cyc1 = 0, acc_first = 0;
  int rsp_rise0 = 0, rsp_hs_cyc0 = 0;
  int cs_rise = 0, cs_fall = 0, cs_len = 0, rdy_rise = 0;
  int both_rdy = 0;
  logic [31:0] last0 = '0, last1 = '0;
  logic prv_cs = 1'b0, prv_rdy = 1'b0, prv_rv0 = 1'b0;

  always @(negedge clk) begin
    if (rstn) begin
      if (req_ready0 && req_ready1) both_rdy++;
      if (req_valid0 && req_ready0) begin
        if (grants.size() == 0) acc_first = cyc;
        acc_cnt0++;
        acc_cyc0 = cyc;
        grants.push_back(0);
        exp0.push_back(fpu_fn(req_func0, req_rs1_0, req_rs2_0, req_rdr0));
      end
      if (req_valid1 && req_ready1) begin
        if (grants.size() == 0) acc_first = cyc;
        acc_cnt1++;
        acc_cyc1 = cyc;
        grants.push_back(1);
        exp1.push_back(fpu_fn(req_func1, req_rs1_1, req_rs2_1, req_rdr1));
      end
      if (rsp_valid0 && !prv_rv0) rsp_rise0 = cyc;
      if (rsp_valid0 && rsp_ready0) begin
        rsp_cnt0++;
        rsp_hs_cyc0 = cyc;
        last0 = rsp_data0;
        if (exp0.size() == 0) chk("rsp0_unexpected", 32'(exp0.size()), 1);
        else chk("rsp0_data", rsp_data0, exp0.pop_front());
      end
      if (rsp_valid1 && rsp_ready1) begin
        rsp_cnt1++;
        last1 = rsp_data1;
        if (exp1.size() == 0) chk("rsp1_unexpected", 32'(exp1.size()), 1);
        else chk("rsp1_data", rsp_data1, exp1.pop_front());
      end
      if (fpu_cs && !prv_cs) cs_rise = cyc;
      if (!fpu_cs && prv_cs) begin
        cs_fall = cyc;
        cs_len  = cyc - cs_rise;
      end
      if (fpu_ready && !prv_rdy) rdy_rise = cyc;
    end
    prv_cs  = fpu_cs;
    prv_rdy = fpu_ready;
    prv_rv0 = rsp_valid0;
  end

  // Drivers hold each queued request on the port until the monitor sees it accepted.
  int pop0 = 0, pop1 = 0;
  initial begin
    req_t r;
    req_valid0 = 1'b0; req_func0 = '0; req_rs1_0 = '0; req_rs2_0 = '0; req_rdr0 = '0;
    forever begin
      @(posedge clk); #2;
      while (pop0 < acc_cnt0) begin
        if (q0.size() > 0) r = q0.pop_front();
        pop0++;
      end
      if (q0.size() > 0) begin
        req_valid0 = 1'b1;
        req_func0 = q0[0].f; req_rs1_0 = q0[0].a; req_rs2_0 = q0[0].b; req_rdr0 = q0[0].c;
      end else req_valid0 = 1'b0;
    end
  end

  initial begin
    req_t r;
    req_valid1 = 1'b0; req_func1 = '0; req_rs1_1 = '0; req_rs2_1 = '0; req_rdr1 = '0;
    forever begin
      @(posedge clk); #2;
      while (pop1 < acc_cnt1) begin
        if (q1.size() > 0) r = q1.pop_front();
        pop1++;
      end
      if (q1.size() > 0) begin
        req_valid1 = 1'b1;
        req_func1 = q1[0].f; req_rs1_1 = q1[0].a; req_rs2_1 = q1[0].b; req_rdr1 = q1[0].c;
      end else req_valid1 = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input int port, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c);
    req_t r;
    r.f = f; r.a = a; r.b = b; r.c = c;
    if (port == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  task automatic wait_acc(input string tag, input int n0, input int n1);
    for (int i = 0; i < 400; i++) begin
      if (acc_cnt0 >= n0 && acc_cnt1 >= n1) break;
      tick();
    end
    chk(tag, 32'(acc_cnt0 >= n0 && acc_cnt1 >= n1), 1);
  endtask

  task automatic wait_rsp(input string tag, input int n0, input int n1);
    for (int i = 0; i < 400; i++) begin
      if (rsp_cnt0 >= n0 && rsp_cnt1 >= n1) break;
      tick();
    end
    chk(tag, 32'(rsp_cnt0 >= n0 && rsp_cnt1 >= n1), 1);
  endtask

  int cs_len_a;

  initial begin
    rstn = 1'b0;
    rsp_ready0 = 1'b1;
    rsp_ready1 = 1'b1;
    repeat (3) tick();
    chk("rst_req_ready0", 32'(req_ready0), 0);
    chk("rst_req_ready1", 32'(req_ready1), 0);
    chk("rst_rsp_valid0", 32'(rsp_valid0), 0);
    chk("rst_rsp_valid1", 32'(rsp_valid1), 0);
    chk("rst_rsp_data0", rsp_data0, 0);
    chk("rst_rsp_data1", rsp_data1, 0);
    chk("rst_fpu_cs", 32'(fpu_cs), 0);
    chk("rst_fpu_func", 32'(fpu_func), 0);
    chk("rst_fpu_rs1", fpu_rs1, 0);
    chk("rst_fpu_rs2", fpu_rs2, 0);
    chk("rst_fpu_rdr", fpu_rdr, 0);
    chk("rst_busy", 32'(busy), 1);

    // Single square, requested from reset release onwards.
    rstn = 1'b1;
    push(0, 3'd1, 32'h40000000, 32'h0, 32'h0);
    wait_acc("a_acc_timeout", 1, 0);
    chk("a_first_accept_cycle", acc_cyc0, DRAIN);
    wait_rsp("a_rsp_timeout", 1, 0);
    chk("a_result", last0, 32'h40800000);
    chk("a_cs_rise", cs_rise, acc_cyc0 + 1);
    chk("a_cs_fall", cs_fall, rdy_rise + 1);
    chk("a_rsp_rise", rsp_rise0, rdy_rise + 1);
    chk("a_single_issue", starts, 1);
    cs_len_a = cs_len;
    tick();
    chk("a_idle_busy", 32'(busy), 0);

    // Square-accumulate on port 1.
    push(1, 3'd2, 32'h40400000, 32'h3F800000, 32'h3F800000);
    wait_rsp("b_rsp_timeout", 1, 1);
    chk("b_result", last1, 32'h40A00000);

    // Response backpressure with port 1 waiting.
    rsp_ready0 = 1'b0;
    push(0, 3'd1, 32'h3FC00000, 32'h0, 32'h0);
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid0) break;
      tick();
    end
    chk("c_rsp_valid_timeout", 32'(rsp_valid0), 1);
    push(1, 3'd1, 32'h41000000, 32'h12345678, 32'h0);
    for (int i = 0; i < 10; i++) begin
      chk("c_hold_valid", 32'(rsp_valid0), 1);
      chk("c_hold_data", rsp_data0, 32'h40100000);
      chk("c_hold_ready1", 32'(req_ready1), 0);
      tick();
    end
    rsp_ready0 = 1'b1;
    wait_acc("c_acc1_timeout", 2, 2);
    chk("c_grant_after_rsp", acc_cyc1, rsp_hs_cyc0 + 1);
    wait_rsp("c_rsp_timeout", 2, 2);

    // Tie arbitration from reset: both ports keep requesting.
    rstn = 1'b0;
    grants.delete();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(0, 3'd1, 32'h10000000 + 32'(i), 32'h00A00000 + 32'(i), 32'h00000100);
      push(1, 3'd2, 32'h20000000 + 32'(i), 32'h00B00000 + 32'(i), 32'h00000200);
    end
    wait_rsp("d_rsp_timeout", 6, 6);
    chk("d_first_accept_cycle", acc_first, DRAIN);
    chk("d_grant_count", 32'(grants.size()), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < grants.size()) chk($sformatf("d_grant%0d", i), grants[i], i % 2);
    end

    // Reset five cycles into BUSY, then a fresh square must flush the stale done.
    push(0, 3'd1, 32'h40400000, 32'h0, 32'h0);
    wait_acc("e_acc_timeout", 7, 6);
    repeat (6) tick();
    rstn = 1'b0;
    exp0.delete();
    tick();
    rstn = 1'b1;
    push(0, 3'd1, 32'h40000000, 32'h0, 32'h0);
    wait_acc("e_acc2_timeout", 8, 6);
    chk("e_accept_cycle", acc_cyc0, DRAIN);
    wait_rsp("e_rsp_timeout", 7, 6);
    chk("e_result", last0, 32'h40800000);
    chk("e_flush_cs_len", cs_len, cs_len_a + 1);
    chk("e_cs_fall", cs_fall, rdy_rise + 1);

    tick();
    chk("end_busy", 32'(busy), 0);
    chk("end_issue_count", starts, acc_cnt0 + acc_cnt1);
    chk("end_func_stable", func_err, 0);
    chk("end_ready_exclusive", both_rdy, 0);
    chk("end_exp0_empty", 32'(exp0.size()), 0);
    chk("end_exp1_empty", 32'(exp1.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
